// File: rtl/usr_pkg.sv
// Shared types for the universal shift register frame sequencer.
// Holds the sequencer state encoding and the frame counter width.
package usr_pkg;

  typedef enum logic [1:0] {
    FILL,
    LOAD,
    CAPTURE,
    FLUSH
  } usr_state_e;

  localparam int FCNT_W = 16;

endpackage

// File: rtl/usr_frame_sequencer.sv
// Stages a SIZE-word frame into a parallel image, then sequences the
// shift register through load, capture and a SIZE-cycle flush.
module usr_frame_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_dir,
  output logic                  load,
  output logic                  ce,
  output logic                  dir,
  output logic [WIDTH-1:0]      data_in,
  output logic [WIDTH*SIZE-1:0] din,
  output logic                  tap_valid,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  usr_state_e            state_q;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         k_q;
  logic                  s_ready_q;
  logic                  load_q;
  logic                  ce_q;
  logic                  dir_q;
  logic [WIDTH*SIZE-1:0] din_q;
  logic                  tap_q;
  logic                  busy_q;
  logic [FCNT_W-1:0]     frame_cnt_q;

  // Frame FSM: fill words, pulse load, wait out capture, then flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      k_q         <= '0;
      s_ready_q   <= 1'b1;
      load_q      <= 1'b0;
      ce_q        <= 1'b0;
      dir_q       <= 1'b0;
      din_q       <= '0;
      tap_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (s_valid && s_ready_q) begin
            for (int i = 0; i < SIZE; i++) begin
              if (idx_q == IW'(i)) begin
                din_q[i*WIDTH +: WIDTH] <= s_data;
              end
            end
            if (idx_q == '0) begin
              dir_q <= s_dir;
            end
            if (idx_q == LAST) begin
              idx_q     <= '0;
              state_q   <= LOAD;
              load_q    <= 1'b1;
              ce_q      <= 1'b1;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        LOAD: begin
          load_q  <= 1'b0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          k_q     <= '0;
          tap_q   <= 1'b1;
          state_q <= FLUSH;
        end
        FLUSH: begin
          if (k_q == LAST) begin
            k_q         <= '0;
            idx_q       <= '0;
            tap_q       <= 1'b0;
            ce_q        <= 1'b0;
            busy_q      <= 1'b0;
            s_ready_q   <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            state_q     <= FILL;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign load      = load_q;
  assign ce        = ce_q;
  assign dir       = dir_q;
  assign data_in   = '0;
  assign din       = din_q;
  assign tap_valid = tap_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_usr_frame_sequencer.sv
// Directed bench for usr_frame_sequencer with a behavioural
// universal shift register model driven by its control outputs.
module tb_usr_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_dir = 1'b0;
  logic        load;
  logic        ce;
  logic        dir;
  logic [7:0]  data_in;
  logic [23:0] din;
  logic        tap_valid;
  logic        busy;
  logic [15:0] frame_cnt;

  usr_frame_sequencer #(.WIDTH(8), .SIZE(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_dir    (s_dir),
    .load     (load),
    .ce       (ce),
    .dir      (dir),
    .data_in  (data_in),
    .din      (din),
    .tap_valid(tap_valid),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Shift register model: load edge detect delays capture by one cycle.
  logic [23:0] sr_q;
  logic        lp_q, lpp_q;
  logic [7:0]  data_out;

  always @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      lp_q  <= 1'b0;
      lpp_q <= 1'b0;
    end else begin
      lp_q  <= load;
      lpp_q <= lp_q;
      if (!ce) sr_q <= '0;
      else if (lp_q && !lpp_q) sr_q <= din;
      else if (dir) sr_q <= {data_in, sr_q[23:8]};
      else sr_q <= {sr_q[15:0], data_in};
    end
  end

  assign data_out = dir ? sr_q[7:0] : sr_q[23:16];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] taps[$];
  int         tap_cyc[$];
  int         loads = 0;
  int         rdy_busy = 0;

  always @(negedge clk) begin
    if (tap_valid) begin
      taps.push_back(data_out);
      tap_cyc.push_back(cyc);
    end
    if (load) loads++;
    if (busy && s_ready) rdy_busy++;
  end

  int n_chk = 0;
  int n_pass = 0;
  int ecyc = 0;
  int fcnt_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic dr);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_dir   = dr;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    ecyc = cyc;
  endtask

  task automatic frame(input logic [7:0] w0, w1, w2,
                       input logic d0, d1, d2, input int gap);
    taps.delete();
    tap_cyc.delete();
    loads = 0;
    send(w0, d0);
    idle(gap);
    send(w1, d1);
    idle(gap);
    send(w2, d2);
  endtask

  function automatic logic [7:0] tap_at(input int i);
    if (i < taps.size()) return taps[i];
    return 8'hxx;
  endfunction

  task automatic chk_taps(input string tag, input logic [7:0] a, b, c);
    chk({tag, "_n"}, 32'(taps.size()), 32'd3);
    chk({tag, "_t0"}, 32'(tap_at(0)), 32'(a));
    chk({tag, "_t1"}, 32'(tap_at(1)), 32'(b));
    chk({tag, "_t2"}, 32'(tap_at(2)), 32'(c));
  endtask

  logic [7:0] cw [6];
  int         acc_cyc [6];

  initial begin
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_tap", 32'(tap_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_din_zero", 32'(data_in), 32'd0);

    frame(8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 1'b1, 0);
    chk("f1_load", 32'(load), 32'd1);
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_ready", 32'(s_ready), 32'd0);
    chk("f1_din", 32'(din), 32'h332211);
    chk("f1_dir", 32'(dir), 32'd1);
    idle(5);
    chk("f1_ready_after", 32'(s_ready), 32'd1);
    chk("f1_busy_after", 32'(busy), 32'd0);
    idle(1);
    chk_taps("f1", 8'h11, 8'h22, 8'h33);
    chk("f1_lat", 32'(tap_cyc.size() > 0 ? tap_cyc[0] : 0),
        32'(ecyc + 2));
    chk("f1_loads", 32'(loads), 32'd1);
    chk("f1_fcnt", 32'(frame_cnt), 32'd1);
    chk("f1_sr_clear", 32'(data_out), 32'd0);

    frame(8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 1'b1, 0);
    chk("f2_dir", 32'(dir), 32'd0);
    idle(6);
    chk_taps("f2", 8'h33, 8'h22, 8'h11);
    chk("f2_fcnt", 32'(frame_cnt), 32'd2);

    frame(8'hA1, 8'hB2, 8'hC3, 1'b1, 1'b0, 1'b0, 2);
    chk("f3_din", 32'(din), 32'hC3B2A1);
    idle(6);
    chk_taps("f3", 8'hA1, 8'hB2, 8'hC3);
    chk("f3_lat", 32'(tap_cyc.size() > 0 ? tap_cyc[0] : 0),
        32'(ecyc + 2));
    chk("f3_fcnt", 32'(frame_cnt), 32'd3);

    cw = '{8'h81, 8'h82, 8'h83, 8'h91, 8'h92, 8'h93};
    taps.delete();
    tap_cyc.delete();
    rdy_busy = 0;
    begin
      int i, g;
      logic acc;
      i = 0;
      g = 0;
      s_valid = 1'b1;
      s_dir = 1'b1;
      while (i < 6 && g < 100) begin
        s_data = cw[i];
        acc = s_ready;
        @(negedge clk);
        if (acc) begin
          acc_cyc[i] = cyc;
          i++;
        end
        g++;
      end
      s_valid = 1'b0;
      chk("f4_accepted", 32'(i), 32'd6);
    end
    idle(7);
    chk("f4_period", 32'(acc_cyc[3] - acc_cyc[0]), 32'd8);
    chk("f4_ntaps", 32'(taps.size()), 32'd6);
    for (int j = 0; j < 6; j++)
      chk($sformatf("f4_t%0d", j), 32'(tap_at(j)), 32'(cw[j]));
    chk("f4_rdy_busy", 32'(rdy_busy), 32'd0);
    chk("f4_fcnt", 32'(frame_cnt), 32'd5);

    frame(8'h05, 8'h06, 8'h07, 1'b1, 1'b1, 1'b1, 0);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_tap", 32'(tap_valid), 32'd0);
    chk("r_ready", 32'(s_ready), 32'd1);
    chk("r_load", 32'(load), 32'd0);
    chk("r_ce", 32'(ce), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_fcnt", 32'(frame_cnt), 32'd0);
    chk("r_din", 32'(din), 32'd0);
    chk("r_sr", 32'(sr_q), 32'd0);
    chk("r_ntaps", 32'(taps.size()), 32'd2);
    frame(8'h44, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 1);
    idle(6);
    chk_taps("r2", 8'h66, 8'h55, 8'h44);
    chk("r2_fcnt", 32'(frame_cnt), 32'd1);

    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("w_pre", 32'(frame_cnt), 32'hFFFF);
    frame(8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1'b1, 0);
    idle(6);
    chk_taps("w", 8'h01, 8'h02, 8'h03);
    chk("w_fcnt", 32'(frame_cnt), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
